// File: rtl/fib_step_engine_pkg.sv
// Shared definitions for the Fibonacci step engine: FSM encoding, default sizes
// and the BCD digit-count helper also used by the display stage.
package fib_step_engine_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } fib_state_t;

    localparam int FIB_W_DEFAULT = 16;
    localparam int FIB_D_DEFAULT = 5;

    // Smallest D with 10^D > 2^w-1, i.e. floor(w*log10(2)) + 1.
    function automatic int bcd_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/fib_step_engine_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, W cycles per word.
// done is high in the cycle whose closing edge completes the conversion; dout is valid then.
module bin2bcd_seq #(
    parameter int W = 16,
    parameter int D = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   din,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] dout
);

    localparam int CW = $clog2(W + 1);
    localparam int SW = 4 * D + W;

    logic [SW-1:0] sr;
    logic [SW-1:0] sr_adj;
    logic [SW-1:0] sr_next;
    logic [CW-1:0] cnt;

    // Each BCD digit is corrected from its own pre-shift value, then the whole word shifts.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < D; i++) begin
            if (sr[W + 4*i +: 4] >= 4'd5) begin
                sr_adj[W + 4*i +: 4] = sr[W + 4*i +: 4] + 4'd3;
            end
        end
        sr_next = sr_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= {{(4*D){1'b0}}, din};
            cnt <= CW'(W);
        end else if (cnt != '0) begin
            sr  <= sr_next;
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CW'(1));
    assign dout = sr_next[SW-1 -: 4*D];

endmodule

// File: rtl/fib_step_engine.sv
// Advances a Fibonacci sequence one term per accepted step pulse, converts each new term
// to packed BCD, buffers one step that arrives mid-conversion and flags overflow stickily.
module fib_step_engine
    import fib_step_engine_pkg::*;
#(
    parameter int W = FIB_W_DEFAULT,
    parameter int D = FIB_D_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           step,
    input  logic           clear,
    output logic [W-1:0]   fib,
    output logic [7:0]     index,
    output logic [4*D-1:0] bcd,
    output logic           bcd_valid,
    output logic           busy,
    output logic           ovf
);

    fib_state_t     state;
    fib_state_t     state_next;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           nxt_ovf;
    logic           pending;
    logic [W:0]     sum;
    logic           accept;
    logic           block;
    logic           restart;
    logic           conv_busy;
    logic           conv_done;
    logic [4*D-1:0] conv_dout;

    assign restart = rst | clear;
    assign sum     = {1'b0, a} + {1'b0, b};

    // nxt_ovf records whether b itself was truncated, i.e. the next term to be shown is unrepresentable.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        block      = 1'b0;
        case (state)
            S_IDLE: begin
                if (step | pending) begin
                    if (!nxt_ovf) begin
                        accept     = 1'b1;
                        state_next = S_CONV;
                    end else begin
                        block = 1'b1;
                    end
                end
            end
            S_CONV: begin
                if (conv_done || !conv_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state     <= S_IDLE;
            a         <= '0;
            b         <= W'(1);
            nxt_ovf   <= 1'b0;
            index     <= 8'd0;
            pending   <= 1'b0;
            ovf       <= 1'b0;
            bcd       <= '0;
            bcd_valid <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a         <= b;
                b         <= sum[W-1:0];
                nxt_ovf   <= sum[W];
                index     <= index + 8'd1;
                busy      <= 1'b1;
                bcd_valid <= 1'b0;
            end
            if (block) begin
                ovf <= 1'b1;
            end
            // In IDLE any buffered step is consumed; in CONV only one extra step is held.
            if (state == S_IDLE) begin
                pending <= 1'b0;
            end else if (step) begin
                pending <= 1'b1;
            end
            if (state == S_CONV && conv_done) begin
                bcd       <= conv_dout;
                bcd_valid <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

    bin2bcd_seq #(
        .W(W),
        .D(D)
    ) u_bin2bcd (
        .clk  (clk),
        .rst  (restart),
        .start(accept),
        .din  (b),
        .busy (conv_busy),
        .done (conv_done),
        .dout (conv_dout)
    );

    assign fib = a;

endmodule
